// File: rtl/adder_share_pkg.sv
// Shared types and helpers for the round-robin adder-sharing arbiter.
// Holds the result-register state encoding, default sizes and pointer advance.
package adder_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_REQ = 4;

    // Pointer moves to the requester just after the one granted, wrapping.
    function automatic int rr_next(input int idx, input int num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester and response channels of the shared-adder arbiter.
// master = requester/consumer side, slave = arbiter side.
interface adder_share_arb_if
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_carry;
    logic [ID_W-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_id
    );

endinterface

// File: rtl/adder_share_arb_rr_grant.sv
// Combinational round-robin grant: first valid requester at or after i_ptr, wrapping.
// Produces a one-hot grant and its binary index; all zero when i_can_accept is low.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_can_accept,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    always_comb begin : search
        int   w_j;
        logic w_found;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_found && i_can_accept && i_req_valid[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin shares one adder among NUM_REQ requesters; 1-cycle registered result,
// 1/cycle throughput, no grant while result is held. ADDARB_SAT_EN saturates on carry.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic               clk,
    input logic               rst,
    adder_share_arb_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_ptr;
    logic [DATA_W-1:0]   r_data;
    logic                r_carry;
    logic [ID_W-1:0]     r_id;

    logic                w_can_accept;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W-1:0]   w_data;

    // Grants are suppressed during reset so nothing is accepted while state is cleared.
    assign w_can_accept = !rst && ((r_state == EMPTY) || bus.rsp_ready);

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .i_req_valid  (bus.req_valid),
        .i_ptr        (r_ptr),
        .i_can_accept (w_can_accept),
        .o_grant      (w_grant),
        .o_idx        (w_idx)
    );

    assign w_xfer        = |w_grant;
    assign bus.req_ready = w_grant;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_a = bus.req_a[i*DATA_W +: DATA_W];
                w_b = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

`ifdef ADDARB_SAT_EN
    assign w_data = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
`else
    assign w_data = w_sum[DATA_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY:   if (w_xfer) w_next_state = FULL;
            FULL:    if (bus.rsp_ready && !w_xfer) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
        end else if (w_xfer) begin
            r_ptr   <= ID_W'(rr_next(int'(w_idx), NUM_REQ));
            r_data  <= w_data;
            r_carry <= w_sum[DATA_W];
            r_id    <= w_idx;
        end
    end

    assign bus.rsp_valid = (r_state == FULL);
    assign bus.rsp_data  = r_data;
    assign bus.rsp_carry = r_carry;
    assign bus.rsp_id    = r_id;

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: vector table for arbitration/add, plus
// hand sequences for backpressure and mid-operation reset.
module tb_adder_share_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_share_arb_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    adder_share_arb #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        rsp_rdy;
        logic [3:0]  exp_ready;
        logic        exp_vld;
        logic [7:0]  exp_data;
        logic        exp_carry;
        logic [1:0]  exp_id;
    } vec_t;

`ifdef ADDARB_SAT_EN
    localparam logic [7:0] OVF_FF01 = 8'hFF;
    localparam logic [7:0] OVF_F020 = 8'hFF;
`else
    localparam logic [7:0] OVF_FF01 = 8'h00;
    localparam logic [7:0] OVF_F020 = 8'h10;
`endif

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check grant before the edge and the result after it.
    task automatic apply(input vec_t v, input string tag);
        bus.req_valid = v.valid;
        bus.req_a     = v.a;
        bus.req_b     = v.b;
        bus.rsp_ready = v.rsp_rdy;
        #4;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        chk({tag, "_vld"},   32'(bus.rsp_valid), 32'(v.exp_vld));
        chk({tag, "_data"},  32'(bus.rsp_data),  32'(v.exp_data));
        chk({tag, "_carry"}, 32'(bus.rsp_carry), 32'(v.exp_carry));
        chk({tag, "_id"},    32'(bus.rsp_id),    32'(v.exp_id));
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;

        vecs[0]  = '{4'b1111, 32'h03020100, 32'h10101010, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0};
        vecs[1]  = '{4'b1111, 32'h03020100, 32'h10101010, 1'b1, 4'b0010, 1'b1, 8'h11, 1'b0, 2'd1};
        vecs[2]  = '{4'b1111, 32'h03020100, 32'h10101010, 1'b1, 4'b0100, 1'b1, 8'h12, 1'b0, 2'd2};
        vecs[3]  = '{4'b1111, 32'h03020100, 32'h10101010, 1'b1, 4'b1000, 1'b1, 8'h13, 1'b0, 2'd3};
        vecs[4]  = '{4'b1111, 32'h03020100, 32'h10101010, 1'b1, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0};
        vecs[5]  = '{4'b0010, 32'h0000FF00, 32'h00000100, 1'b1, 4'b0010, 1'b1, OVF_FF01, 1'b1, 2'd1};
        vecs[6]  = '{4'b0100, 32'h00F00000, 32'h00200000, 1'b1, 4'b0100, 1'b1, OVF_F020, 1'b1, 2'd2};
        vecs[7]  = '{4'b0100, 32'h00330000, 32'h00440000, 1'b1, 4'b0100, 1'b1, 8'h77, 1'b0, 2'd2};
        vecs[8]  = '{4'b0100, 32'h00010000, 32'h00020000, 1'b1, 4'b0100, 1'b1, 8'h03, 1'b0, 2'd2};
        vecs[9]  = '{4'b0001, 32'h00000005, 32'h00000006, 1'b1, 4'b0001, 1'b1, 8'h0B, 1'b0, 2'd0};
        vecs[10] = '{4'b0101, 32'h00400007, 32'h00020001, 1'b1, 4'b0100, 1'b1, 8'h42, 1'b0, 2'd2};
        vecs[11] = '{4'b0101, 32'h00400007, 32'h00020001, 1'b1, 4'b0001, 1'b1, 8'h08, 1'b0, 2'd0};
        vecs[12] = '{4'b0101, 32'h00400007, 32'h00020001, 1'b1, 4'b0100, 1'b1, 8'h42, 1'b0, 2'd2};
        vecs[13] = '{4'b0000, 32'h00000000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h42, 1'b0, 2'd2};

        // Reset with every requester asking.
        rst           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_a     = 32'h03020100;
        bus.req_b     = 32'h10101010;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_vld",   32'(bus.rsp_valid), 32'h0);
        chk("rst_data",  32'(bus.rsp_data),  32'h0);
        chk("rst_carry", 32'(bus.rsp_carry), 32'h0);
        chk("rst_id",    32'(bus.rsp_id),    32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Backpressure: result held, no grants, release accepts in the same cycle.
        v = '{4'b0010, 32'h00002000, 32'h00000500, 1'b1, 4'b0010, 1'b1, 8'h25, 1'b0, 2'd1};
        apply(v, "bp_load");
        for (int c = 0; c < 3; c++) begin
            v = '{4'b1111, 32'h00010000, 32'h00010000, 1'b0, 4'b0000, 1'b1, 8'h25, 1'b0, 2'd1};
            apply(v, $sformatf("bp_hold%0d", c));
        end
        v = '{4'b1111, 32'h00010000, 32'h00010000, 1'b1, 4'b0100, 1'b1, 8'h02, 1'b0, 2'd2};
        apply(v, "bp_release");

        // Asynchronous reset while a result is held.
        bus.req_valid = 4'b0000;
        bus.rsp_ready = 1'b0;
        #4;
        rst = 1'b1;
        #1;
        chk("mrst_vld",   32'(bus.rsp_valid), 32'h0);
        chk("mrst_ready", 32'(bus.req_ready), 32'h0);
        chk("mrst_data",  32'(bus.rsp_data),  32'h0);
        @(posedge clk);
        @(negedge clk);
        rst           = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mrst_post_vld",  32'(bus.rsp_valid), 32'h0);
        chk("mrst_post_data", 32'(bus.rsp_data),  32'h0);
        v = '{4'b1000, 32'h0A000000, 32'h0B000000, 1'b1, 4'b1000, 1'b1, 8'h15, 1'b0, 2'd3};
        apply(v, "mrst_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_arb.md
Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one DATA_W-bit adder between NUM_REQ requesters.
- The adder is the same add datapath that drives the chip outputs.
- Each requester presents an operand pair with valid/ready. The block grants one pair per cycle, performs the add, and returns a registered result tagged with the requester ID on a single valid/ready response channel.
- Sits between the pin-level input demux and the output driver in the top-level wrapper.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_W, 8, operand and result width.
- ID_W, $clog2(NUM_REQ), width of the requester tag; derived, do not override.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester accept. At most one bit is set in any cycle.
- req_a  in  NUM_REQ*DATA_W  operand A. Requester i uses bits [i*DATA_W +: DATA_W].
- req_b  in  NUM_REQ*DATA_W  operand B, same packing as req_a.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  downstream accepts the result.
- rsp_data  out  DATA_W  sum.
- rsp_carry  out  1  carry-out of the add.
- rsp_id  out  ID_W  index of the requester that produced the result.

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0.
  - Round-robin pointer = 0; FSM = EMPTY.
  - req_ready=0 while rst is asserted.
- FSM states:
  - EMPTY: result register free.
  - FULL: result register holds an unconsumed result.
- can_accept = (state==EMPTY) or (state==FULL and rsp_ready).
- Grant, combinational:
  - When can_accept is true, grant the first i with req_valid[i]=1.
  - Search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready is the one-hot grant vector; all zero if there is no valid request or can_accept=0.
- Transfer:
  - A request transfer occurs on a cycle with req_valid[i] & req_ready[i].
  - On that edge, register {rsp_carry, rsp_data} = req_a[i] + req_b[i] at DATA_W+1 bits, unsigned, and rsp_id = i.
  - Latency is 1 cycle from the transfer edge to rsp_valid=1.
- Pointer: after a transfer from i, ptr becomes (i+1) mod NUM_REQ. The pointer is unchanged if there is no transfer.
- Transitions:
  - EMPTY with transfer -> FULL.
  - FULL with rsp_ready and transfer -> FULL. New result loaded; back-to-back throughput is 1 result per cycle.
  - FULL with rsp_ready and no transfer -> EMPTY.
  - FULL without rsp_ready -> FULL. The result and tag are held stable and req_ready stays all zero.
- Response rules:
  - rsp_valid = (state==FULL).
  - rsp_data, rsp_carry and rsp_id change only on a transfer edge.
- Requester rules:
  - A requester must hold req_a and req_b stable while req_valid=1 and not yet granted.
  - The block must not depend on req_valid deasserting after a grant.
- Boundary conditions:
  - All requesters valid continuously: grants rotate 0,1,2,3,0,...
  - A single requester valid continuously: granted every accepting cycle.
  - 0xFF+0x01: rsp_data=0x00, rsp_carry=1.
  - ptr at NUM_REQ-1 wraps to 0.
  - rst asserted mid-operation drops any held result; it is not replayed.

Optional Feature:
- Macro: ADDARB_SAT_EN.
- Defined: when the add carries out, rsp_data = all-ones (0xFF for DATA_W=8). rsp_carry is still reported as 1.
- Undefined: rsp_data is the wrap-around sum modulo 2^DATA_W.
- Handshake, latency and arbitration are identical in both builds.

Decomposition:
- Package adder_share_pkg holds:
  - the state enum type (EMPTY, FULL);
  - default localparams for DATA_W and NUM_REQ;
  - a function computing the next round-robin pointer.
- Natural sub-module: rr_grant. It is purely combinational and takes req_valid, ptr and can_accept. It outputs a one-hot grant and the binary grant index.
- The adder and the result register stay in adder_share_arb.

Test Plan:
- Reset: hold rst=1 with all req_valid=1 -> req_ready=0000, rsp_valid=0. Release -> first grant is req 0.
- Round robin: all 4 valid with a_i=i, b_i=0x10, rsp_ready=1 -> results tagged 0,1,2,3,0 on consecutive cycles, data 0x10,0x11,0x12,0x13,0x10.
- Backpressure: req1 a=0x20 b=0x05, rsp_ready=0 for 3 cycles:
  - rsp_valid=1, rsp_data=0x25, rsp_id=1 held stable;
  - req_ready=0 on all requesters throughout;
  - raising rsp_ready accepts the next request in the same cycle.
- Overflow: a=0xFF, b=0x01 -> rsp_data=0x00, carry=1. With ADDARB_SAT_EN: a=0xF0, b=0x20 -> rsp_data=0xFF, carry=1.
- Fairness skip: only req2 and req0 valid, ptr=1 -> grant 2, then 0, then 2.
- Mid-operation reset: assert rst while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately (asynchronous), and no stale result appears after release.
